// File: rtl/batcharger_ctrl_if.sv
// batcharger_ctrl_if: charger control bus between the controller (slave) and its host/power stage (master)
interface batcharger_ctrl_if #(
  parameter int W = 10
);
  logic         en;
  logic [3:0]   sel;
  logic         sample_valid;
  logic [W-1:0] vbat_adc;
  logic [W-1:0] ibat_adc;
  logic [W-1:0] vtemp_adc;
  logic         tc;
  logic         cc;
  logic         cv;
  logic [W-1:0] iref;
  logic [W-1:0] vref;
  logic         done;
  logic         fault;
  modport master (
    output en, sel, sample_valid, vbat_adc, ibat_adc, vtemp_adc,
    input  tc, cc, cv, iref, vref, done, fault
  );
  modport slave (
    input  en, sel, sample_valid, vbat_adc, ibat_adc, vtemp_adc,
    output tc, cc, cv, iref, vref, done, fault
  );
endinterface

// File: rtl/batcharger_ctrl.sv
// batcharger_ctrl: Li-ion TC/CC/CV charge sequencer with debounce, safety timers, temperature fault and auto-recharge
module batcharger_ctrl #(
  parameter int W        = 10,
  parameter int ICC_STEP = 20,
  parameter int VCUTOFF  = 600,
  parameter int VFULL    = 840,
  parameter int VRECHG   = 800,
  parameter int TMIN     = 100,
  parameter int TMAX     = 400,
  parameter int DEB      = 3,
  parameter int TCW      = 16,
  parameter int TC_MAX   = 1000,
  parameter int CV_MAX   = 5000
) (
  input logic clk,
  input logic rst,
  batcharger_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, TC, CC, CV, DONE, FAULT} state_t;
  localparam logic [W-1:0] VC  = W'(VCUTOFF);
  localparam logic [W-1:0] VF  = W'(VFULL);
  localparam logic [W-1:0] VR  = W'(VRECHG);
  localparam logic [W-1:0] TLO = W'(TMIN);
  localparam logic [W-1:0] THI = W'(TMAX);
  localparam logic [3:0]   DB  = 4'(DEB);
  localparam logic [TCW:0] TCL = (TCW+1)'(TC_MAX);
  localparam logic [TCW:0] CVL = (TCW+1)'(CV_MAX);
  state_t         state, nxt;
  logic [3:0]     sel_q, nxt_sel, deb_q;
  logic [TCW-1:0] tmr;
  logic [TCW:0]   tmr_inc;
  logic [W+3:0]   mul;
  logic [W-1:0]   icc, iterm;
  logic           hot, qual, deb_hit, clr;
  // sel tracks the input while idle so the value seen on IDLE exit is the one held
  assign nxt_sel = state == IDLE ? bus.sel : sel_q;
  assign mul     = (W+4)'({1'b0, nxt_sel} + 5'd1) * (W+4)'(ICC_STEP);
  assign icc     = |mul[W+3:W] ? '1 : mul[W-1:0];
  assign iterm   = icc >> 4;
  assign tmr_inc = {1'b0, tmr} + (TCW+1)'(1);
  assign hot     = bus.vtemp_adc < TLO || bus.vtemp_adc > THI;
  assign qual    = state == TC   ? bus.vbat_adc >= VC :
                   state == CC   ? bus.vbat_adc >= VF :
                   state == CV   ? bus.ibat_adc < iterm :
                   state == DONE ? bus.vbat_adc < VR : 1'b0;
  assign deb_hit = qual && (deb_q + 4'd1) == DB;
  always_comb begin
    nxt = state;
    if (!bus.en)
      nxt = IDLE;
    else if (bus.sample_valid)
      case (state)
        IDLE:    nxt = bus.vbat_adc < VC ? TC : CC;
        TC:      nxt = hot || tmr_inc == TCL ? FAULT : deb_hit ? CC : TC;
        CC:      nxt = hot ? FAULT : deb_hit ? CV : CC;
        CV:      nxt = hot ? FAULT : deb_hit || tmr_inc == CVL ? DONE : CV;
        DONE:    nxt = deb_hit ? (bus.vbat_adc < VC ? TC : CC) : DONE;
        default: nxt = state;
      endcase
  end
  assign clr = nxt != state || !bus.en;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel_q     <= '0;
      deb_q     <= '0;
      tmr       <= '0;
      bus.tc    <= 1'b0;
      bus.cc    <= 1'b0;
      bus.cv    <= 1'b0;
      bus.done  <= 1'b0;
      bus.fault <= 1'b0;
      bus.iref  <= '0;
      bus.vref  <= '0;
    end else begin
      state     <= nxt;
      sel_q     <= nxt_sel;
      deb_q     <= clr ? '0 : bus.sample_valid ? (qual ? deb_q + 4'd1 : '0) : deb_q;
      tmr       <= clr ? '0 : bus.sample_valid && !(&tmr) ? tmr_inc[TCW-1:0] : tmr;
      bus.tc    <= nxt == TC;
      bus.cc    <= nxt == CC;
      bus.cv    <= nxt == CV;
      bus.done  <= nxt == DONE;
      bus.fault <= nxt == FAULT;
      bus.iref  <= nxt == TC ? icc >> 3 : (nxt == CC || nxt == CV) ? icc : '0;
      bus.vref  <= (nxt == TC || nxt == CC || nxt == CV) ? VF : '0;
    end
  end
endmodule

// File: tb/tb_batcharger_ctrl.sv
// tb_batcharger_ctrl: directed checks of the charge sequence, debounce, timers, faults and async reset
module tb_batcharger_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  batcharger_ctrl_if #(.W(10)) ia ();
  batcharger_ctrl_if #(.W(10)) ib ();
  batcharger_ctrl dut_a (.clk(clk), .rst(rst), .bus(ia));
  batcharger_ctrl #(.ICC_STEP(100), .TC_MAX(5)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic samp(input bit b, input logic [9:0] vb, input logic [9:0] ibt, input logic [9:0] vt);
    @(negedge clk);
    if (b) begin
      ib.vbat_adc = vb; ib.ibat_adc = ibt; ib.vtemp_adc = vt; ib.sample_valid = 1'b1;
    end else begin
      ia.vbat_adc = vb; ia.ibat_adc = ibt; ia.vtemp_adc = vt; ia.sample_valid = 1'b1;
    end
    @(negedge clk);
    ia.sample_valid = 1'b0;
    ib.sample_valid = 1'b0;
  endtask
  function automatic logic [31:0] mode_a();
    return {27'd0, ia.tc, ia.cc, ia.cv, ia.done, ia.fault};
  endfunction
  function automatic logic [31:0] mode_b();
    return {27'd0, ib.tc, ib.cc, ib.cv, ib.done, ib.fault};
  endfunction
  initial begin
    ia.en = 0; ia.sel = 4'd8; ia.sample_valid = 0; ia.vbat_adc = 0; ia.ibat_adc = 100; ia.vtemp_adc = 250;
    ib.en = 0; ib.sel = 4'd15; ib.sample_valid = 0; ib.vbat_adc = 0; ib.ibat_adc = 100; ib.vtemp_adc = 250;
    #1 rst = 1'b1;
    #2;
    chk("reset_mode", mode_a(), 5'b00000);
    chk("reset_iref", ia.iref, 0);
    chk("reset_vref", ia.vref, 0);
    @(negedge clk) rst = 1'b0;
    ia.en = 1'b1;
    samp(0, 500, 100, 250);
    chk("tc_entry_mode", mode_a(), 5'b10000);
    chk("tc_itc", ia.iref, 22);
    chk("tc_vref", ia.vref, 840);
    samp(0, 650, 100, 250);
    samp(0, 650, 100, 250);
    chk("tc_deb2_mode", mode_a(), 5'b10000);
    samp(0, 650, 100, 250);
    chk("cc_mode", mode_a(), 5'b01000);
    chk("cc_icc", ia.iref, 180);
    samp(0, 845, 100, 250);
    samp(0, 845, 100, 250);
    samp(0, 700, 100, 250);
    samp(0, 845, 100, 250);
    samp(0, 845, 100, 250);
    chk("cc_deb_reset_mode", mode_a(), 5'b01000);
    samp(0, 845, 100, 250);
    chk("cv_mode", mode_a(), 5'b00100);
    chk("cv_iref", ia.iref, 180);
    chk("cv_vref", ia.vref, 840);
    samp(0, 845, 10, 250);
    samp(0, 845, 10, 250);
    chk("cv_deb2_mode", mode_a(), 5'b00100);
    samp(0, 845, 10, 250);
    chk("done_mode", mode_a(), 5'b00010);
    chk("done_iref", ia.iref, 0);
    chk("done_vref", ia.vref, 0);
    for (int i = 0; i < 3; i++) samp(0, 790, 100, 250);
    chk("rechg_cc_mode", mode_a(), 5'b01000);
    for (int i = 0; i < 3; i++) samp(0, 845, 100, 250);
    for (int i = 0; i < 3; i++) samp(0, 845, 11, 250);
    chk("cv_iterm_edge_mode", mode_a(), 5'b00100);
    for (int i = 0; i < 3; i++) samp(0, 845, 10, 250);
    chk("done2_mode", mode_a(), 5'b00010);
    samp(0, 790, 100, 250);
    samp(0, 790, 100, 250);
    samp(0, 590, 100, 250);
    chk("rechg_tc_mode", mode_a(), 5'b10000);
    chk("rechg_tc_iref", ia.iref, 22);
    samp(0, 590, 100, 100);
    chk("tmin_edge_mode", mode_a(), 5'b10000);
    samp(0, 590, 100, 400);
    chk("tmax_edge_mode", mode_a(), 5'b10000);
    for (int i = 0; i < 3; i++) samp(0, 600, 100, 250);
    chk("vcutoff_edge_mode", mode_a(), 5'b01000);
    samp(0, 700, 100, 450);
    chk("hot_fault_mode", mode_a(), 5'b00001);
    chk("hot_fault_iref", ia.iref, 0);
    samp(0, 700, 100, 250);
    chk("fault_hold_mode", mode_a(), 5'b00001);
    ia.en = 1'b0;
    @(negedge clk);
    chk("en_off_mode", mode_a(), 5'b00000);
    ia.en = 1'b1;
    samp(0, 500, 100, 250);
    samp(0, 500, 100, 99);
    chk("cold_fault_mode", mode_a(), 5'b00001);
    ia.en = 1'b0;
    @(negedge clk);
    chk("cold_clear_mode", mode_a(), 5'b00000);
    ib.en = 1'b1;
    samp(1, 500, 100, 250);
    chk("b_tc_iref", ib.iref, 127);
    for (int i = 0; i < 4; i++) samp(1, 500, 100, 250);
    chk("b_tc4_mode", mode_b(), 5'b10000);
    samp(1, 500, 100, 250);
    chk("b_timeout_mode", mode_b(), 5'b00001);
    ib.en = 1'b0;
    @(negedge clk);
    ib.en = 1'b1;
    samp(1, 650, 100, 250);
    chk("b_cc_mode", mode_b(), 5'b01000);
    chk("b_icc_sat", ib.iref, 1023);
    ia.en = 1'b1;
    samp(0, 845, 100, 250);
    for (int i = 0; i < 3; i++) samp(0, 845, 100, 250);
    chk("pre_rst_cv_mode", mode_a(), 5'b00100);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mode", mode_a(), 5'b00000);
    chk("async_rst_iref", ia.iref, 0);
    chk("async_rst_vref", ia.vref, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle_mode", mode_a(), 5'b00000);
    samp(0, 500, 100, 250);
    chk("post_rst_tc_mode", mode_a(), 5'b10000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
